// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module   : md_unit
// Purpose  : E-stage multiply/divide unit. Latches operands from the D/E
//            pipeline register, holds HI/LO, and reports busy so the hazard
//            logic can stall while a multi-cycle MD operation is in flight.
//            Optional macro MD_MADD_EN enables madd/maddu (op 7/8); when it
//            is undefined those ops behave as no-ops and no accumulate adder
//            is built.
// Revision : 1.0 - initial release
// ============================================================================
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
`endif

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic [3:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        w_load;
  logic [31:0] w_hi_nxt;
  logic [31:0] w_lo_nxt;

  // Arithmetic datapath signals (all derived from the latched operands)
  logic        w_mul_signed;
  logic [63:0] w_ext_a;
  logic [63:0] w_ext_b;
  logic [63:0] w_prod;
  logic        w_div_signed;
  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_div_den;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;
`ifdef MD_MADD_EN
  logic [63:0] w_acc;
`endif

  // Multiply: sign/zero extend to 64 bits; the low 64 bits of the product
  // are correct for both signed and unsigned interpretations.
  always_comb begin
`ifdef MD_MADD_EN
    w_mul_signed = (r_op == OP_MULT) || (r_op == OP_MADD);
`else
    w_mul_signed = (r_op == OP_MULT);
`endif
    w_ext_a = {{32{w_mul_signed & r_a[31]}}, r_a};
    w_ext_b = {{32{w_mul_signed & r_b[31]}}, r_b};
    w_prod  = w_ext_a * w_ext_b;
  end

  // Divide on magnitudes, then restore signs. This avoids relying on signed
  // division semantics for 0x80000000 / -1, whose magnitude quotient
  // 0x80000000 is already the wrapped result we need.
  always_comb begin
    w_div_signed = (r_op == OP_DIV);
    w_neg_a      = w_div_signed & r_a[31];
    w_neg_b      = w_div_signed & r_b[31];
    w_mag_a      = w_neg_a ? (32'd0 - r_a) : r_a;
    w_mag_b      = w_neg_b ? (32'd0 - r_b) : r_b;
    // Divisor of zero never commits, so any safe value keeps the divider sane
    w_div_den    = (w_mag_b == 32'd0) ? 32'd1 : w_mag_b;
    w_uq         = w_mag_a / w_div_den;
    w_ur         = w_mag_a % w_div_den;
    w_quot       = (w_neg_a ^ w_neg_b) ? (32'd0 - w_uq) : w_uq;
    w_rem        = w_neg_a ? (32'd0 - w_ur) : w_ur;
  end

`ifdef MD_MADD_EN
  // Accumulate uses HI/LO as they stand at the completion edge
  always_comb begin
    w_acc = {hi, lo} + w_prod;
  end
`endif

  // Select the HI/LO value to commit when the running op completes
  always_comb begin
    w_res_hi = hi;
    w_res_lo = lo;
    case (r_op)
      OP_MULT, OP_MULTU: begin
        w_res_hi = w_prod[63:32];
        w_res_lo = w_prod[31:0];
      end
      OP_DIV, OP_DIVU: begin
        if (r_b != 32'd0) begin
          w_res_hi = w_rem;
          w_res_lo = w_quot;
        end
      end
`ifdef MD_MADD_EN
      OP_MADD, OP_MADDU: begin
        w_res_hi = w_acc[63:32];
        w_res_lo = w_acc[31:0];
      end
`endif
      default: begin
        w_res_hi = hi;
        w_res_lo = lo;
      end
    endcase
  end

  // Next-state, counter and HI/LO update decisions
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_hi_nxt    = hi;
    w_lo_nxt    = lo;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              w_load      = 1'b1;
              w_cnt_nxt   = MULT_CNT;
              w_state_nxt = ST_RUN;
            end
`ifdef MD_MADD_EN
            OP_MADD, OP_MADDU: begin
              w_load      = 1'b1;
              w_cnt_nxt   = MULT_CNT;
              w_state_nxt = ST_RUN;
            end
`endif
            OP_DIV, OP_DIVU: begin
              w_load      = 1'b1;
              w_cnt_nxt   = DIV_CNT;
              w_state_nxt = ST_RUN;
            end
            OP_MTHI: w_hi_nxt = a;
            OP_MTLO: w_lo_nxt = a;
            default: w_load   = 1'b0;
          endcase
        end
      end
      ST_RUN: begin
        // Any start while running is ignored; hazard logic stalls instead
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) begin
          w_cnt_nxt   = 4'd0;
          w_state_nxt = ST_IDLE;
          w_hi_nxt    = w_res_hi;
          w_lo_nxt    = w_res_lo;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset abandons any op in flight without writing HI/LO
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_op    <= 4'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      hi      <= w_hi_nxt;
      lo      <= w_lo_nxt;
      if (w_load) begin
        r_op <= op;
        r_a  <= a;
        r_b  <= b;
      end
    end
  end

  assign busy = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_md_unit
// Purpose  : Directed self-checking bench for md_unit with hand-computed
//            expected HI/LO and busy timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_md_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks;
  int n_fails;

  md_unit #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present an op for one edge, then scramble a/b so latching is exercised.
  // Returns at the negedge following the start edge.
  task automatic issue(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    @(negedge clk);
    start = 1'b0;
    op    = 4'd0;
    a     = $urandom;
    b     = $urandom;
  endtask

  // Expect busy high for exactly n sampled cycles, then low.
  // Returns at the first idle-cycle negedge.
  task automatic expect_busy(input int n, input string tag);
    check({tag, "_busy1"}, {31'd0, busy}, 32'd1);
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      check({tag, "_busyN"}, {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    check({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset = 1'b0;
    start = 1'b0;
    op    = 4'd0;
    a     = 32'd0;
    b     = 32'd0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;

    // Signed multiply -2 * 3
    issue(4'd1, 32'hFFFF_FFFE, 32'd3);
    check("mult_hold_lo", lo, 32'd0);
    expect_busy(5, "mult");
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);

    // Unsigned multiply 0xFFFFFFFE * 3 = 0x2_FFFFFFFA
    issue(4'd2, 32'hFFFF_FFFE, 32'd3);
    expect_busy(5, "multu");
    check("multu_hi", hi, 32'h0000_0002);
    check("multu_lo", lo, 32'hFFFF_FFFA);

    // Signed divide -7 / 2 -> q=-3, r=-1
    issue(4'd3, 32'hFFFF_FFF9, 32'd2);
    expect_busy(10, "div");
    check("div_hi", hi, 32'hFFFF_FFFF);
    check("div_lo", lo, 32'hFFFF_FFFD);

    // Unsigned divide by zero leaves HI/LO unchanged
    issue(4'd4, 32'd7, 32'd0);
    expect_busy(10, "divu0");
    check("divu0_hi", hi, 32'hFFFF_FFFF);
    check("divu0_lo", lo, 32'hFFFF_FFFD);

    // Overflow case 0x80000000 / -1
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    expect_busy(10, "divovf");
    check("divovf_hi", hi, 32'h0000_0000);
    check("divovf_lo", lo, 32'h8000_0000);

    // Back-to-back: 100/7 -> q=14 r=2, then mtlo in the cycle busy falls
    issue(4'd3, 32'd100, 32'd7);
    expect_busy(10, "b2b");
    check("b2b_hi", hi, 32'd2);
    check("b2b_lo", lo, 32'd14);
    start = 1'b1;
    op    = 4'd6;
    a     = 32'h0000_ABCD;
    @(negedge clk);
    start = 1'b0;
    op    = 4'd0;
    check("b2b_mtlo_lo", lo, 32'h0000_ABCD);
    check("b2b_mtlo_hi", hi, 32'd2);
    check("b2b_mtlo_busy", {31'd0, busy}, 32'd0);

    // Busy masking: mthi and operand changes during RUN are ignored
    issue(4'd1, 32'd2, 32'd3);
    check("mask_busy1", {31'd0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b1;
    op    = 4'd5;
    a     = 32'h0000_1234;
    b     = 32'h0000_0055;
    @(negedge clk);
    start = 1'b0;
    op    = 4'd0;
    check("mask_hi_hold", hi, 32'd2);
    check("mask_busy3", {31'd0, busy}, 32'd1);
    repeat (2) @(negedge clk);
    check("mask_busy5", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("mask_busy_fall", {31'd0, busy}, 32'd0);
    check("mask_hi", hi, 32'd0);
    check("mask_lo", lo, 32'd6);
    issue(4'd5, 32'h0000_1234, 32'd0);
    check("mthi_hi", hi, 32'h0000_1234);
    check("mthi_lo", lo, 32'd6);
    check("mthi_busy", {31'd0, busy}, 32'd0);

    // Reset mid-RUN abandons the divide
    issue(4'd3, 32'd50, 32'd3);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    check("midrst_late_hi", hi, 32'd0);
    check("midrst_late_lo", lo, 32'd0);
    check("midrst_late_busy", {31'd0, busy}, 32'd0);

    // Accumulate ops: preset hi=0, lo=0xFFFFFFFF
    issue(4'd5, 32'd0, 32'd0);
    issue(4'd6, 32'hFFFF_FFFF, 32'd0);
    check("preset_lo", lo, 32'hFFFF_FFFF);
`ifdef MD_MADD_EN
    issue(4'd8, 32'd1, 32'd1);
    expect_busy(5, "maddu");
    check("maddu_hi", hi, 32'd1);
    check("maddu_lo", lo, 32'd0);
    issue(4'd7, 32'hFFFF_FFFF, 32'd1);
    expect_busy(5, "madd");
    check("madd_hi", hi, 32'd0);
    check("madd_lo", lo, 32'hFFFF_FFFF);
`else
    issue(4'd8, 32'd1, 32'd1);
    check("maddu_off_busy", {31'd0, busy}, 32'd0);
    repeat (6) @(negedge clk);
    check("maddu_off_busy_late", {31'd0, busy}, 32'd0);
    check("maddu_off_hi", hi, 32'd0);
    check("maddu_off_lo", lo, 32'hFFFF_FFFF);
`endif

    // Undefined op is a no-op
    issue(4'd9, 32'h1111_1111, 32'h2222_2222);
    check("op9_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("op9_hi", hi, 32'd0);
    check("op9_lo", lo, 32'hFFFF_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
